// File: rtl/sand_sweep.sv
// ============================================================================
// Module   : sand_sweep
// Brief    : Bottom-up full-frame sweep presenting region/floor word pairs of a
//            2-bit-per-cell frame buffer to external cell-update logic and
//            writing the results back. Optional spout flag: SAND_SPOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sand_sweep #(
    parameter int WORDS_PER_ROW = 40,
    parameter int ROWS          = 480,
    parameter int ADDR_W        = 15,
    parameter int SPOUT_COL     = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       region,
    output logic [31:0]       floor,
    output logic              screenbegin,
    output logic              screenend,
    output logic              screenbottom,
    output logic              spout,
    input  logic [31:0]       new_region,
    input  logic [31:0]       new_floor
);

    localparam int COL_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam int ROW_W = (ROWS > 2) ? $clog2(ROWS) : 1;

    localparam logic [ROW_W-1:0]  c_ROW_INIT   = ROW_W'(ROWS - 2);
    localparam logic [ROW_W-1:0]  c_ROW_BOTTOM = ROW_W'(ROWS - 2);
    localparam logic [COL_W-1:0]  c_COL_LAST   = COL_W'(WORDS_PER_ROW - 1);
    localparam logic [ADDR_W-1:0] c_RADDR_INIT = ADDR_W'((ROWS - 2) * WORDS_PER_ROW);
    localparam logic [ADDR_W-1:0] c_FADDR_INIT = ADDR_W'((ROWS - 1) * WORDS_PER_ROW);
    // Stepping from the last word of row r to the first word of row r-1.
    localparam logic [ADDR_W-1:0] c_ROW_STEP   = ADDR_W'(2 * WORDS_PER_ROW - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_R = 3'd1,
        RD_F = 3'd2,
        CAP  = 3'd3,
        WR_R = 3'd4,
        WR_F = 3'd5
    } state_t;

    state_t            r_state;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [ADDR_W-1:0] r_raddr;
    logic [ADDR_W-1:0] r_faddr;
    logic              r_busy;
    logic              r_done;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_region;
    logic [31:0]       r_floor;
    logic              r_begin;
    logic              r_end;
    logic              r_bottom;

    logic              w_col_last;
    logic              w_last_word;
    logic [COL_W-1:0]  w_next_col;
    logic [ROW_W-1:0]  w_next_row;
    logic [ADDR_W-1:0] w_next_raddr;
    logic [ADDR_W-1:0] w_next_faddr;
    logic              w_flag_load;
    logic              w_flag_clr;
    logic [ROW_W-1:0]  w_flag_row;
    logic [COL_W-1:0]  w_flag_col;

    if (SPOUT_COL < 0 || SPOUT_COL >= WORDS_PER_ROW) begin : g_spout_col_range
        localparam int c_SPOUT_COL_INVALID = SPOUT_COL;
    end

    assign w_col_last   = (r_col == c_COL_LAST);
    assign w_last_word  = w_col_last && (r_row == '0);
    assign w_next_col   = w_col_last ? '0 : r_col + COL_W'(1);
    assign w_next_row   = w_col_last ? r_row - ROW_W'(1) : r_row;
    assign w_next_raddr = w_col_last ? r_raddr - c_ROW_STEP : r_raddr + ADDR_W'(1);
    assign w_next_faddr = w_col_last ? r_faddr - c_ROW_STEP : r_faddr + ADDR_W'(1);

    // Flags are loaded for the word about to start: the current (initial)
    // position on an accepted start, the advanced position otherwise.
    assign w_flag_load = ((r_state == IDLE) && start) || ((r_state == WR_F) && !w_last_word);
    assign w_flag_clr  = (r_state == WR_F) && w_last_word;
    assign w_flag_row  = (r_state == IDLE) ? r_row : w_next_row;
    assign w_flag_col  = (r_state == IDLE) ? r_col : w_next_col;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_row    <= c_ROW_INIT;
            r_col    <= '0;
            r_raddr  <= c_RADDR_INIT;
            r_faddr  <= c_FADDR_INIT;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_region <= '0;
            r_floor  <= '0;
            r_begin  <= 1'b0;
            r_end    <= 1'b0;
            r_bottom <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_flag_load) begin
                r_begin  <= (w_flag_col == '0);
                r_end    <= (w_flag_col == c_COL_LAST);
                r_bottom <= (w_flag_row == c_ROW_BOTTOM);
            end else if (w_flag_clr) begin
                r_begin  <= 1'b0;
                r_end    <= 1'b0;
                r_bottom <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RD_R;
                        r_busy  <= 1'b1;
                        r_addr  <= r_raddr;
                    end
                end
                RD_R: begin
                    r_state <= RD_F;
                    r_addr  <= r_faddr;
                end
                RD_F: begin
                    r_state  <= CAP;
                    r_region <= mem_rdata;
                end
                CAP: begin
                    r_state <= WR_R;
                    r_floor <= mem_rdata;
                    r_addr  <= r_raddr;
                    r_we    <= 1'b1;
                end
                WR_R: begin
                    r_state <= WR_F;
                    r_addr  <= r_faddr;
                end
                WR_F: begin
                    r_we <= 1'b0;
                    if (w_last_word) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_addr  <= '0;
                        r_row   <= c_ROW_INIT;
                        r_col   <= '0;
                        r_raddr <= c_RADDR_INIT;
                        r_faddr <= c_FADDR_INIT;
                    end else begin
                        r_state <= RD_R;
                        r_addr  <= w_next_raddr;
                        r_row   <= w_next_row;
                        r_col   <= w_next_col;
                        r_raddr <= w_next_raddr;
                        r_faddr <= w_next_faddr;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_we    <= 1'b0;
                    r_addr  <= '0;
                end
            endcase
        end
    end

`ifdef SAND_SPOUT_EN
    logic r_spout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_spout <= 1'b0;
        end else if (w_flag_load) begin
            r_spout <= (w_flag_row == '0) && (w_flag_col == COL_W'(SPOUT_COL));
        end else if (w_flag_clr) begin
            r_spout <= 1'b0;
        end
    end

    assign spout = r_spout;
`else
    assign spout = 1'b0;
`endif

    // Write data follows the update logic directly: floor is only captured
    // on the edge entering WR_R, so a registered copy would be a cycle late.
    always_comb begin
        mem_wdata = '0;
        if (r_state == WR_R) begin
            mem_wdata = new_region;
        end else if (r_state == WR_F) begin
            mem_wdata = new_floor;
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign mem_we       = r_we;
    assign mem_addr     = r_addr;
    assign region       = r_region;
    assign floor        = r_floor;
    assign screenbegin  = r_begin;
    assign screenend    = r_end;
    assign screenbottom = r_bottom;

endmodule

`default_nettype wire

// File: tb/tb_sand_sweep.sv
// ============================================================================
// Module   : tb_sand_sweep
// Brief    : Directed bench for sand_sweep on a 2-word x 3-row frame buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sand_sweep;

    localparam int c_ADDR_W = 15;

    logic                clk;
    logic                reset_n;
    logic                start;
    logic                busy;
    logic                done;
    logic [c_ADDR_W-1:0] mem_addr;
    logic                mem_we;
    logic [31:0]         mem_wdata;
    logic [31:0]         mem_rdata;
    logic [31:0]         region;
    logic [31:0]         floor;
    logic                screenbegin;
    logic                screenend;
    logic                screenbottom;
    logic                spout;
    logic [31:0]         new_region;
    logic [31:0]         new_floor;

    logic [31:0] mem [0:15];

    int checks   = 0;
    int failures = 0;

    sand_sweep #(
        .WORDS_PER_ROW (2),
        .ROWS          (3),
        .ADDR_W        (c_ADDR_W),
        .SPOUT_COL     (1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .region       (region),
        .floor        (floor),
        .screenbegin  (screenbegin),
        .screenend    (screenend),
        .screenbottom (screenbottom),
        .spout        (spout),
        .new_region   (new_region),
        .new_floor    (new_floor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous frame buffer: read data valid the cycle after the address.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[3:0]];
    end

    // A grain falls into an empty floor cell and lands as a settled grain (2'b10).
    always_comb begin
        new_region = region;
        new_floor  = floor;
        for (int i = 0; i < 16; i++) begin
            if (region[2*i +: 2] != 2'b00 && floor[2*i +: 2] == 2'b00) begin
                new_region[2*i +: 2] = 2'b00;
                new_floor[2*i +: 2]  = 2'b10;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int ra [4];
        int fa [4];
        int w;
        int p;
        logic exp_spout;
        ra = '{2, 3, 0, 1};
        fa = '{4, 5, 2, 3};
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[2]  = 32'h4000_0000;
        reset_n = 1'b0;
        start   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_region", region, 32'd0);
        chk("rst_floor", floor, 32'd0);
        chk("rst_flags", {28'd0, screenbegin, screenend, screenbottom, spout}, 32'd0);

        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Full sweep; extra start pulses at edge 7 (busy) and edge 20 (with done).
        start = 1'b1;
        for (int cyc = 0; cyc < 22; cyc++) begin
            @(posedge clk);
            #1;
            start = (cyc == 6 || cyc == 19);
            if (cyc < 20) begin
                w = cyc / 5;
                p = cyc % 5;
`ifdef SAND_SPOUT_EN
                exp_spout = (w == 3);
`else
                exp_spout = 1'b0;
`endif
                chk("sweep_busy", {31'd0, busy}, 32'd1);
                chk("sweep_done", {31'd0, done}, 32'd0);
                chk("sweep_we", {31'd0, mem_we}, (p >= 3) ? 32'd1 : 32'd0);
                if (p == 0 || p == 3) chk("sweep_raddr", 32'(mem_addr), ra[w]);
                if (p == 1 || p == 4) chk("sweep_faddr", 32'(mem_addr), fa[w]);
                if (p >= 3) chk("sweep_wdata", mem_wdata, (cyc == 4) ? 32'h8000_0000 : 32'd0);
                chk("sweep_flags", {28'd0, screenbegin, screenend, screenbottom, spout},
                    {28'd0, (w % 2 == 0), (w % 2 == 1), (w < 2), exp_spout});
                if (cyc == 3) begin
                    chk("word0_region", region, 32'h4000_0000);
                    chk("word0_floor", floor, 32'd0);
                end
            end else if (cyc == 20) begin
                chk("end_done", {31'd0, done}, 32'd1);
                chk("end_busy", {31'd0, busy}, 32'd0);
                chk("end_we", {31'd0, mem_we}, 32'd0);
                chk("end_addr", 32'(mem_addr), 32'd0);
            end else begin
                chk("post_done", {31'd0, done}, 32'd0);
                chk("post_busy_ignored_start", {31'd0, busy}, 32'd0);
            end
        end
        chk("mem2_after", mem[2], 32'd0);
        chk("mem4_after", mem[4], 32'h8000_0000);

        // Sweep interrupted by reset at cycle 12, during word (r=0,c=0).
        @(negedge clk);
        mem[0] = 32'h1234_5678;
        mem[2] = 32'h0;
        start  = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("pre_rst_region", region, 32'h1234_5678);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_region", region, 32'd0);
        chk("mid_rst_flags", {28'd0, screenbegin, screenend, screenbottom, spout}, 32'd0);
        repeat (2) @(posedge clk);
        chk("mid_rst_mem0", mem[0], 32'h1234_5678);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Restart after reset must begin again from row ROWS-2, column 0.
        start = 1'b1;
        for (int cyc = 0; cyc < 21; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            chk("restart_done", {31'd0, done}, (cyc == 20) ? 32'd1 : 32'd0);
            if (cyc % 5 == 0 && cyc < 20) begin
                chk("restart_raddr", 32'(mem_addr), ra[cyc / 5]);
                chk("restart_bottom", {31'd0, screenbottom}, (cyc < 10) ? 32'd1 : 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
